// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control unit for the MIPS-lite datapath.
// Runs each instruction through FETCH/DECODE/EXEC/MEM/WB, drives the ifu
// PC-update controls, IR/regfile/ALU/data-memory controls, and counts
// retired instructions. An unsupported op/funct pair parks the unit in TRAP.
module mc_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ins_valid,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        ir_we,
    output logic        pc_we,
    output logic        npc_sel,
    output logic        jctl,
    output logic        reg_we,
    output logic        reg_dst,
    output logic        alu_src,
    output logic        ext_op,
    output logic [1:0]  alu_op,
    output logic        mem_we,
    output logic        mem_to_reg,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [31:0] icount
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd7
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_LUI = 2'b11;

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] icount_r;
    logic        illegal_r;

    logic is_addu_s, is_subu_s, is_ori_s, is_lui_s;
    logic is_lw_s, is_sw_s, is_beq_s, is_j_s, is_legal_s;

    logic ir_we_s, pc_we_s, reg_we_s, mem_we_s;
    logic npc_sel_s, jctl_s, retire_s;

    // Instruction decode from the IR opcode and function fields.
    always_comb begin
        is_addu_s  = (op == 6'h00) && (funct == 6'h21);
        is_subu_s  = (op == 6'h00) && (funct == 6'h23);
        is_ori_s   = (op == 6'h0D);
        is_lui_s   = (op == 6'h0F);
        is_lw_s    = (op == 6'h23);
        is_sw_s    = (op == 6'h2B);
        is_beq_s   = (op == 6'h04);
        is_j_s     = (op == 6'h02);
        is_legal_s = is_addu_s | is_subu_s | is_ori_s | is_lui_s |
                     is_lw_s | is_sw_s | is_beq_s | is_j_s;
    end

    // Static datapath controls; only meaningful in EXEC/MEM/WB.
    always_comb begin
        reg_dst    = is_addu_s | is_subu_s;
        alu_src    = is_ori_s | is_lui_s | is_lw_s | is_sw_s;
        ext_op     = is_lw_s | is_sw_s | is_beq_s;
        mem_to_reg = is_lw_s;
        if (is_subu_s || is_beq_s) begin
            alu_op = ALU_SUB;
        end else if (is_ori_s) begin
            alu_op = ALU_OR;
        end else if (is_lui_s) begin
            alu_op = ALU_LUI;
        end else begin
            alu_op = ALU_ADD;
        end
    end

    // Next-state logic and state-gated enables for the instruction sequencer.
    always_comb begin
        next_state_s = state_r;
        ir_we_s      = 1'b0;
        pc_we_s      = 1'b0;
        reg_we_s     = 1'b0;
        mem_we_s     = 1'b0;
        npc_sel_s    = 1'b0;
        jctl_s       = 1'b0;
        retire_s     = 1'b0;
        case (state_r)
            FETCH: begin
                ir_we_s = ins_valid;
                pc_we_s = ins_valid;
                if (ins_valid) begin
                    next_state_s = DECODE;
                end else begin
                    next_state_s = FETCH;
                end
            end
            DECODE: begin
                if (is_j_s) begin
                    pc_we_s      = 1'b1;
                    jctl_s       = 1'b1;
                    retire_s     = 1'b1;
                    next_state_s = FETCH;
                end else if (!is_legal_s) begin
                    next_state_s = TRAP;
                end else begin
                    next_state_s = EXEC;
                end
            end
            EXEC: begin
                if (is_beq_s) begin
                    npc_sel_s    = 1'b1;
                    pc_we_s      = zero;
                    retire_s     = 1'b1;
                    next_state_s = FETCH;
                end else if (is_lw_s || is_sw_s) begin
                    next_state_s = MEM;
                end else begin
                    next_state_s = WB;
                end
            end
            MEM: begin
                if (is_sw_s) begin
                    mem_we_s     = 1'b1;
                    retire_s     = 1'b1;
                    next_state_s = FETCH;
                end else begin
                    next_state_s = WB;
                end
            end
            WB: begin
                reg_we_s     = 1'b1;
                retire_s     = 1'b1;
                next_state_s = FETCH;
            end
            TRAP: begin
                next_state_s = TRAP;
            end
            default: begin
                next_state_s = FETCH;
            end
        endcase
    end

    // Write enables drop the instant reset asserts, even mid-cycle.
    always_comb begin
        ir_we   = ir_we_s  & reset_n;
        pc_we   = pc_we_s  & reset_n;
        reg_we  = reg_we_s & reset_n;
        mem_we  = mem_we_s & reset_n;
        npc_sel = npc_sel_s;
        jctl    = jctl_s;
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Retired-instruction counter; wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            icount_r <= 32'd0;
        end else if (retire_s) begin
            icount_r <= icount_r + 32'd1;
        end else begin
            icount_r <= icount_r;
        end
    end

    // Sticky illegal flag, set together with entry into TRAP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_r <= 1'b0;
        end else if (next_state_s == TRAP) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    assign state   = state_r;
    assign icount  = icount_r;
    assign illegal = illegal_r;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed testbench for mc_ctrl. Inputs change 1 ns after the rising edge,
// outputs are sampled 3 ns after the rising edge (well before the next edge).
module tb_mc_ctrl;

    logic        clk;
    logic        reset_n;
    logic        ins_valid;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        ir_we, pc_we, npc_sel, jctl, reg_we, reg_dst, alu_src, ext_op;
    logic [1:0]  alu_op;
    logic        mem_we, mem_to_reg, illegal;
    logic [2:0]  state;
    logic [31:0] icount;

    int checks;
    int errors;
    logic [31:0] exp_icount;

    mc_ctrl dut (
        .clk(clk), .reset_n(reset_n), .ins_valid(ins_valid), .op(op),
        .funct(funct), .zero(zero), .ir_we(ir_we), .pc_we(pc_we),
        .npc_sel(npc_sel), .jctl(jctl), .reg_we(reg_we), .reg_dst(reg_dst),
        .alu_src(alu_src), .ext_op(ext_op), .alu_op(alu_op), .mem_we(mem_we),
        .mem_to_reg(mem_to_reg), .state(state), .illegal(illegal),
        .icount(icount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ins_valid = 1'b1; op = 6'h00; funct = 6'h21; zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if (icount !== 32'd0) begin errors++; $display("FAIL reset_icount got %0d exp 0", icount); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b exp 0", illegal); end
        checks++; if ({ir_we, pc_we} !== 2'b00) begin errors++; $display("FAIL reset_we_forced got %b exp 00", {ir_we, pc_we}); end
        reset_n = 1'b1;
        exp_icount = 32'd0;
        #2;
        checks++; if ({ir_we, pc_we} !== 2'b11) begin errors++; $display("FAIL fetch_we got %b exp 11", {ir_we, pc_we}); end
    endtask

    task automatic test_addu();
        logic [2:0] exp_st [4];
        exp_st = '{3'd0, 3'd1, 3'd2, 3'd4};
        op = 6'h00; funct = 6'h21; ins_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #2;
            checks++; if (state !== exp_st[c]) begin errors++; $display("FAIL addu_state c%0d got %0d exp %0d", c, state, exp_st[c]); end
            checks++; if (reg_we !== (c == 3)) begin errors++; $display("FAIL addu_reg_we c%0d got %b", c, reg_we); end
            if (c == 3) begin
                checks++; if ({reg_dst, alu_op} !== 3'b100) begin errors++; $display("FAIL addu_ctl got %b exp 100", {reg_dst, alu_op}); end
            end
            next_cycle();
        end
        exp_icount = exp_icount + 32'd1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL addu_end_state got %0d exp 0", state); end
        checks++; if (icount !== exp_icount) begin errors++; $display("FAIL addu_icount got %0d exp %0d", icount, exp_icount); end
    endtask

    task automatic test_beq();
        op = 6'h04; funct = 6'h00; ins_valid = 1'b1;
        for (int z = 1; z >= 0; z--) begin
            zero = z[0];
            next_cycle();
            next_cycle();
            #2;
            checks++; if (state !== 3'd2) begin errors++; $display("FAIL beq_exec_state z%0d got %0d exp 2", z, state); end
            checks++; if (npc_sel !== 1'b1) begin errors++; $display("FAIL beq_npc_sel z%0d got %b exp 1", z, npc_sel); end
            checks++; if (pc_we !== z[0]) begin errors++; $display("FAIL beq_pc_we z%0d got %b exp %b", z, pc_we, z[0]); end
            checks++; if ({ext_op, alu_op} !== 3'b101) begin errors++; $display("FAIL beq_ctl got %b exp 101", {ext_op, alu_op}); end
            next_cycle();
            exp_icount = exp_icount + 32'd1;
            checks++; if (state !== 3'd0) begin errors++; $display("FAIL beq_end_state z%0d got %0d exp 0", z, state); end
        end
        zero = 1'b0;
        checks++; if (icount !== exp_icount) begin errors++; $display("FAIL beq_icount got %0d exp %0d", icount, exp_icount); end
    endtask

    task automatic test_lw_sw();
        logic [2:0] exp_st [5];
        exp_st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        op = 6'h23; funct = 6'h00; ins_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++; if ({state, ir_we, pc_we} !== 5'b000_00) begin errors++; $display("FAIL lw_wait c%0d got %b exp 00000", c, {state, ir_we, pc_we}); end
            next_cycle();
        end
        ins_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #2;
            checks++; if (state !== exp_st[c]) begin errors++; $display("FAIL lw_state c%0d got %0d exp %0d", c, state, exp_st[c]); end
            if (c == 0) begin
                checks++; if ({ir_we, pc_we} !== 2'b11) begin errors++; $display("FAIL lw_fetch_we got %b exp 11", {ir_we, pc_we}); end
            end
            if (c == 4) begin
                checks++; if ({mem_to_reg, reg_we, alu_src, mem_we} !== 4'b1110) begin errors++; $display("FAIL lw_wb_ctl got %b exp 1110", {mem_to_reg, reg_we, alu_src, mem_we}); end
            end
            next_cycle();
        end
        exp_icount = exp_icount + 32'd1;
        op = 6'h2B;
        for (int c = 0; c < 4; c++) begin
            #2;
            checks++; if (state !== exp_st[c]) begin errors++; $display("FAIL sw_state c%0d got %0d exp %0d", c, state, exp_st[c]); end
            checks++; if (mem_we !== (c == 3)) begin errors++; $display("FAIL sw_mem_we c%0d got %b", c, mem_we); end
            checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL sw_reg_we c%0d got %b exp 0", c, reg_we); end
            next_cycle();
        end
        exp_icount = exp_icount + 32'd1;
        checks++; if ({state, icount} !== {3'd0, exp_icount}) begin errors++; $display("FAIL sw_end got st %0d cnt %0d exp st 0 cnt %0d", state, icount, exp_icount); end
    endtask

    task automatic test_jump();
        op = 6'h02; ins_valid = 1'b1;
        #2;
        checks++; if (jctl !== 1'b0) begin errors++; $display("FAIL j_fetch_jctl got %b exp 0", jctl); end
        next_cycle();
        #2;
        checks++; if ({state, pc_we, jctl} !== 5'b001_11) begin errors++; $display("FAIL j_decode got %b exp 00111", {state, pc_we, jctl}); end
        next_cycle();
        exp_icount = exp_icount + 32'd1;
        checks++; if ({state, icount} !== {3'd0, exp_icount}) begin errors++; $display("FAIL j_end got st %0d cnt %0d exp st 0 cnt %0d", state, icount, exp_icount); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [3];
        logic [5:0] fns [3];
        logic [3:0] exp_ctl [3];
        ops = '{6'h00, 6'h0D, 6'h0F};
        fns = '{6'h23, 6'h00, 6'h00};
        // {reg_dst, alu_src, alu_op}
        exp_ctl = '{4'b1001, 4'b0110, 4'b0111};
        ins_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            op = ops[i]; funct = fns[i];
            repeat (3) next_cycle();
            #2;
            checks++; if ({state, reg_we} !== 4'b100_1) begin errors++; $display("FAIL b2b_wb i%0d got %b exp 1001", i, {state, reg_we}); end
            checks++; if ({reg_dst, alu_src, alu_op} !== exp_ctl[i]) begin errors++; $display("FAIL b2b_ctl i%0d got %b exp %b", i, {reg_dst, alu_src, alu_op}, exp_ctl[i]); end
            checks++; if ({ext_op, mem_to_reg} !== 2'b00) begin errors++; $display("FAIL b2b_ext i%0d got %b exp 00", i, {ext_op, mem_to_reg}); end
            next_cycle();
            exp_icount = exp_icount + 32'd1;
        end
        checks++; if (icount !== exp_icount) begin errors++; $display("FAIL b2b_icount got %0d exp %0d", icount, exp_icount); end
    endtask

    task automatic test_illegal();
        op = 6'h3F; ins_valid = 1'b1;
        next_cycle();
        next_cycle();
        for (int c = 0; c < 10; c++) begin
            #2;
            checks++; if ({state, illegal} !== 4'b111_1) begin errors++; $display("FAIL trap c%0d got %b exp 1111", c, {state, illegal}); end
            checks++; if ({ir_we, pc_we, reg_we, mem_we} !== 4'b0000) begin errors++; $display("FAIL trap_we c%0d got %b exp 0000", c, {ir_we, pc_we, reg_we, mem_we}); end
            checks++; if (icount !== exp_icount) begin errors++; $display("FAIL trap_icount c%0d got %0d exp %0d", c, icount, exp_icount); end
            next_cycle();
        end
        reset_n = 1'b0;
        #1;
        checks++; if ({state, illegal, icount} !== {3'd0, 1'b0, 32'd0}) begin errors++; $display("FAIL trap_reset got st %0d ill %b cnt %0d exp 0 0 0", state, illegal, icount); end
        exp_icount = 32'd0;
        next_cycle();
        reset_n = 1'b1;
    endtask

    task automatic test_async_reset();
        op = 6'h2B; ins_valid = 1'b1;
        // retire one addu first so the count is nonzero before the abort
        op = 6'h00; funct = 6'h21;
        repeat (4) next_cycle();
        exp_icount = exp_icount + 32'd1;
        op = 6'h2B;
        repeat (3) next_cycle();
        #1;
        checks++; if ({state, mem_we, icount} !== {3'd3, 1'b1, exp_icount}) begin errors++; $display("FAIL ar_mem got st %0d we %b cnt %0d", state, mem_we, icount); end
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL ar_mem_we got %b exp 0", mem_we); end
        checks++; if ({state, icount} !== {3'd0, 32'd0}) begin errors++; $display("FAIL ar_state got st %0d cnt %0d exp 0 0", state, icount); end
        next_cycle();
        reset_n = 1'b1;
        next_cycle();
        #2;
        checks++; if ({state, icount} !== {3'd1, 32'd0}) begin errors++; $display("FAIL ar_restart got st %0d cnt %0d exp 1 0", state, icount); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_addu();
        test_beq();
        test_lw_sw();
        test_jump();
        test_back_to_back();
        test_illegal();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout exceeded");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit that sequences the instruction fetch unit (ifu) and the rest of the MIPS-lite datapath. It runs each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the ifu's PC-update controls (pc_we, npc_sel, jctl). It also drives the IR latch, register-file, ALU and data-memory controls, and counts retired instructions. It sits between the instruction register and the ifu/datapath.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ins_valid  in  1  instruction memory word valid (fetch handshake).
- op  in  6  IR[31:26]. Stable from DECODE until the instruction retires.
- funct  in  6  IR[5:0]. Same stability as op.
- zero  in  1  ALU zero flag. Valid in EXEC.
- ir_we  out  1  latch the instruction into IR.
- pc_we  out  1  ifu PC update enable.
- npc_sel  out  1  ifu branch select (the ifu takes the branch when npc_sel & zero).
- jctl  out  1  ifu jump select.
- reg_we  out  1  register-file write.
- reg_dst  out  1  1 = rd, 0 = rt.
- alu_src  out  1  1 = immediate operand.
- ext_op  out  1  1 = sign-extend, 0 = zero-extend.
- alu_op  out  2  00 add, 01 sub, 10 or, 11 lui.
- mem_we  out  1  data-memory write.
- mem_to_reg  out  1  1 = write-back data comes from memory.
- state  out  3  current state (debug).
- illegal  out  1  sticky illegal-opcode flag.
- icount  out  32  retired-instruction counter.

## Operation
- Supported instructions:
  - addu: op 00, funct 21.
  - subu: op 00, funct 23.
  - ori: op 0D.
  - lui: op 0F.
  - lw: op 23.
  - sw: op 2B.
  - beq: op 04.
  - j: op 02.
  - Any other op/funct pair is illegal.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7. Values 5 and 6 are unused and go to FETCH.
- FETCH:
  - ir_we = pc_we = ins_valid, with npc_sel = jctl = 0 (PC+4).
  - Go to DECODE when ins_valid = 1; otherwise hold.
- DECODE:
  - j: pc_we = jctl = 1, retire, go to FETCH.
  - Illegal: go to TRAP.
  - Otherwise go to EXEC.
- EXEC:
  - beq: npc_sel = 1, pc_we = zero, retire, go to FETCH.
  - lw/sw: go to MEM.
  - addu/subu/ori/lui: go to WB.
- MEM:
  - sw: mem_we = 1, retire, go to FETCH.
  - lw: go to WB.
- WB: reg_we = 1, retire, go to FETCH.
- TRAP: illegal = 1, all write enables are 0, stays in TRAP until reset.
- Static controls are decoded combinationally from op/funct and are don't-care outside EXEC/MEM/WB:
  - reg_dst = 1 for addu/subu.
  - alu_src = 1 for ori/lui/lw/sw.
  - ext_op = 1 for lw/sw/beq.
  - alu_op: sub for subu/beq, or for ori, lui for lui, add otherwise.
  - mem_to_reg = 1 only for lw.
- Write enables (ir_we, pc_we, reg_we, mem_we) are gated by state and are never asserted outside the states listed above.
- Retire: icount increments by 1 on the clock edge that leaves the retiring state. It wraps FFFFFFFF -> 0.

## Timing
- While reset_n = 0:
  - state = 0, icount = 0, illegal = 0.
  - ir_we, pc_we, reg_we and mem_we are forced to 0 combinationally.
  - This holds from any state, including mid-instruction; the partial instruction is abandoned and not counted.
- State, icount and illegal are registered. All control outputs are combinational from state, op, funct, zero and ins_valid.
- Cycles per instruction, excluding fetch wait cycles: j 2, beq 3, sw 4, addu/subu/ori/lui 4, lw 5.
- Each cycle with ins_valid = 0 in FETCH adds one cycle; state and enables hold.
- beq not taken (zero = 0) still takes 3 cycles and still retires.
- pc_we and ir_we assert in FETCH in the same cycle ins_valid = 1.

## Test plan
- addu (op 00, funct 21), ins_valid = 1 constant -> states 0,1,2,4,0. reg_we is 1 only in the WB cycle, with reg_dst = 1 and alu_op = 00. icount = 1.
- beq with zero = 1, then again with zero = 0 -> both take 3 cycles each. First: npc_sel = 1 and pc_we = 1 in EXEC. Second: npc_sel = 1 and pc_we = 0 in EXEC. icount = 2.
- lw with ins_valid low for 3 cycles -> FETCH holds 3 cycles with ir_we = pc_we = 0, then 0,1,2,3,4. mem_to_reg = 1, reg_we = 1 and alu_src = 1 in WB. sw -> mem_we = 1 in MEM only.
- j (op 02) -> pc_we = jctl = 1 in DECODE, back in FETCH after 2 cycles, icount +1.
- op 3F -> state 7, illegal = 1. Holds for 10 cycles with all write enables 0 and icount unchanged. reset_n pulse -> state 0, illegal 0.
- Assert reset_n = 0 asynchronously mid-cycle while in MEM of an sw -> mem_we drops immediately, state = 0, icount = 0.
